// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Central sequencing controller for the 5-stage pipeline. It merges three
// stall/flush sources into one set of pipeline-register enables:
//   - data-cache miss freeze (highest priority, holds every stage and the PC)
//   - load-use hazard bubble resolved in ID
//   - taken-branch IF/ID flush
// A RUN/MISS/ERR FSM tracks miss episodes and a 16-bit latency counter acts as
// a miss watchdog. Performance counters are built only when the macro
// HAZARD_PERF_CNT_EN is defined; otherwise their outputs are tied to zero.
//
// Parameters:
//   ADDR_W        register address width
//   CNT_W         width of each saturating performance counter
//   MISS_TIMEOUT  miss-wait cycles before the watchdog fires (1..2^16-1)
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   ID_RS1addr_i/RS2      source registers of the instruction in ID
//   EX_MemRead_i/RDaddr   load flag and destination of the instruction in EX
//   ID_BranchTaken_i      branch in ID resolved taken
//   MEM_CacheStall_i      data cache busy servicing a miss
//   PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, Freeze_o
//                         combinational pipeline controls (zero latency)
//   MissActive_o          registered, FSM is in MISS or ERR
//   TimeoutErr_o          sticky watchdog error, cleared only by reset
//   LoadUseCnt_o, MissCycleCnt_o, MissEventCnt_o, FlushCnt_o, MaxMissLat_o
//                         performance counters (zero when not built)
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MISS_TIMEOUT = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] ID_RS1addr_i,
    input  logic [ADDR_W-1:0] ID_RS2addr_i,
    input  logic              EX_MemRead_i,
    input  logic [ADDR_W-1:0] EX_RDaddr_i,
    input  logic              ID_BranchTaken_i,
    input  logic              MEM_CacheStall_i,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o,
    output logic              NoOp_o,
    output logic              Flush_o,
    output logic              Freeze_o,
    output logic              MissActive_o,
    output logic              TimeoutErr_o,
    output logic [CNT_W-1:0]  LoadUseCnt_o,
    output logic [CNT_W-1:0]  MissCycleCnt_o,
    output logic [CNT_W-1:0]  MissEventCnt_o,
    output logic [CNT_W-1:0]  FlushCnt_o,
    output logic [15:0]       MaxMissLat_o
);

    localparam int unsigned LAT_W = 16;
    localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};
    localparam logic [LAT_W-1:0] TIMEOUT = LAT_W'(MISS_TIMEOUT);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        ERR  = 2'd2
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [LAT_W-1:0] latency;
    logic [LAT_W-1:0] latencyNext;
    logic [LAT_W-1:0] latencyInc;
    logic             timeoutErr;
    logic             timeoutErrNext;
    logic             loadUse;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    // x0 is hard-wired to zero, so a load targeting it never stalls.
    assign loadUse = EX_MemRead_i
                   && (EX_RDaddr_i != '0)
                   && ((EX_RDaddr_i == ID_RS1addr_i) || (EX_RDaddr_i == ID_RS2addr_i));

    // Prioritised pipeline controls; reset forces the free-running defaults.
    always_comb begin
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
        NoOp_o      = 1'b0;
        Flush_o     = 1'b0;
        Freeze_o    = 1'b0;
        if (rst_i) begin
            if (MEM_CacheStall_i) begin
                Freeze_o    = 1'b1;
                PCWrite_o   = 1'b0;
                IFIDWrite_o = 1'b0;
            end else if (loadUse) begin
                // A concurrent taken branch is dropped here; ID holds, so the
                // branch is resolved again next cycle.
                PCWrite_o   = 1'b0;
                IFIDWrite_o = 1'b0;
                NoOp_o      = 1'b1;
            end else if (ID_BranchTaken_i) begin
                Flush_o     = 1'b1;
            end
        end
    end

    // Saturating increment of the episode latency.
    assign latencyInc = (latency == LAT_MAX) ? latency : latency + LAT_W'(1);

    // Miss-episode FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= RUN;
            latency    <= '0;
            timeoutErr <= 1'b0;
        end else begin
            state      <= stateNext;
            latency    <= latencyNext;
            timeoutErr <= timeoutErrNext;
        end
    end

    // Miss-episode next state, latency tracking and watchdog.
    always_comb begin
        stateNext      = state;
        latencyNext    = latency;
        timeoutErrNext = timeoutErr;
        case (state)
            RUN: begin
                if (MEM_CacheStall_i) begin
                    latencyNext = LAT_W'(1);
                    // A timeout of one cycle is already reached on entry.
                    if (TIMEOUT <= LAT_W'(1)) begin
                        stateNext      = ERR;
                        timeoutErrNext = 1'b1;
                    end else begin
                        stateNext = MISS;
                    end
                end
            end
            MISS: begin
                if (MEM_CacheStall_i) begin
                    latencyNext = latencyInc;
                    if (latencyInc >= TIMEOUT) begin
                        stateNext      = ERR;
                        timeoutErrNext = 1'b1;
                    end
                end else begin
                    stateNext   = RUN;
                    latencyNext = '0;
                end
            end
            ERR: begin
                // Watchdog already fired; keep measuring so the max is honest.
                if (MEM_CacheStall_i) begin
                    latencyNext = latencyInc;
                end else begin
                    stateNext   = RUN;
                    latencyNext = '0;
                end
            end
            default: begin
                stateNext   = RUN;
                latencyNext = '0;
            end
        endcase
    end

    assign MissActive_o = (state != RUN);
    assign TimeoutErr_o = timeoutErr;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] loadUseCnt;
    logic [CNT_W-1:0] missCycleCnt;
    logic [CNT_W-1:0] missEventCnt;
    logic [CNT_W-1:0] flushCnt;
    logic [LAT_W-1:0] maxMissLat;
    logic             missStart;
    logic             missEnd;

    // Episode boundaries seen from the FSM: entry from RUN, exit to RUN.
    assign missStart = (state == RUN) && MEM_CacheStall_i;
    assign missEnd   = (state != RUN) && !MEM_CacheStall_i;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating event counters and the longest completed miss.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            loadUseCnt   <= '0;
            missCycleCnt <= '0;
            missEventCnt <= '0;
            flushCnt     <= '0;
            maxMissLat   <= '0;
        end else begin
            if (NoOp_o) begin
                loadUseCnt <= satInc(loadUseCnt);
            end
            if (Freeze_o) begin
                missCycleCnt <= satInc(missCycleCnt);
            end
            if (missStart) begin
                missEventCnt <= satInc(missEventCnt);
            end
            if (Flush_o) begin
                flushCnt <= satInc(flushCnt);
            end
            // latency still holds the full episode length on the exit edge.
            if (missEnd && (latency > maxMissLat)) begin
                maxMissLat <= latency;
            end
        end
    end

    assign LoadUseCnt_o   = loadUseCnt;
    assign MissCycleCnt_o = missCycleCnt;
    assign MissEventCnt_o = missEventCnt;
    assign FlushCnt_o     = flushCnt;
    assign MaxMissLat_o   = maxMissLat;
`else
    assign LoadUseCnt_o   = '0;
    assign MissCycleCnt_o = '0;
    assign MissEventCnt_o = '0;
    assign FlushCnt_o     = '0;
    assign MaxMissLat_o   = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Self-checking bench for hazard_stall_ctrl. A behavioural model tracks the
// pipeline controls from the priority rules and the miss bookkeeping as
// "length of the current run of stall cycles"; directed scenarios use
// hand-derived constants, the random scenario compares every output to the
// model each cycle. Counter expectations collapse to zero when the design is
// built without HAZARD_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 6;
    localparam int unsigned TO   = 9;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_i;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          memRead;
    logic [AW-1:0] rd;
    logic          branch;
    logic          stall;
    logic          pcWrite, ifidWrite, noOp, flush, freeze;
    logic          missActive, timeoutErr;
    logic [CW-1:0] loadUseCnt, missCycleCnt, missEventCnt, flushCnt;
    logic [15:0]   maxMissLat;
    logic [4:0]    combObs;

    int checks = 0;
    int errors = 0;

    // Model state
    int mLoadUse, mMissCyc, mMissEv, mFlush, mMax, mLat;
    bit mPrevStall, mErr;

    hazard_stall_ctrl #(
        .ADDR_W(AW),
        .CNT_W(CW),
        .MISS_TIMEOUT(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .ID_RS1addr_i(rs1),
        .ID_RS2addr_i(rs2),
        .EX_MemRead_i(memRead),
        .EX_RDaddr_i(rd),
        .ID_BranchTaken_i(branch),
        .MEM_CacheStall_i(stall),
        .PCWrite_o(pcWrite),
        .IFIDWrite_o(ifidWrite),
        .NoOp_o(noOp),
        .Flush_o(flush),
        .Freeze_o(freeze),
        .MissActive_o(missActive),
        .TimeoutErr_o(timeoutErr),
        .LoadUseCnt_o(loadUseCnt),
        .MissCycleCnt_o(missCycleCnt),
        .MissEventCnt_o(missEventCnt),
        .FlushCnt_o(flushCnt),
        .MaxMissLat_o(maxMissLat)
    );

    assign combObs = {pcWrite, ifidWrite, noOp, flush, freeze};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    // Expected {PCWrite, IFIDWrite, NoOp, Flush, Freeze} from current inputs.
    function automatic logic [4:0] expComb();
        bit lu;
        lu = memRead && (rd != 0) && ((rd == rs1) || (rd == rs2));
        if (!rst_i)      return 5'b11000;
        if (stall)       return 5'b00001;
        if (lu)          return 5'b00100;
        if (branch)      return 5'b11010;
        return 5'b11000;
    endfunction

    task automatic modelReset();
        mLoadUse = 0; mMissCyc = 0; mMissEv = 0; mFlush = 0;
        mMax = 0; mLat = 0; mPrevStall = 0; mErr = 0;
    endtask

    // Advance the model by one clock using the inputs of the ending cycle.
    task automatic modelStep();
        logic [4:0] e;
        e = expComb();
        if (e[0]) mMissCyc = sat(mMissCyc);
        if (e[2]) mLoadUse = sat(mLoadUse);
        if (e[1]) mFlush   = sat(mFlush);
        if (stall) begin
            if (!mPrevStall) begin
                mLat    = 1;
                mMissEv = sat(mMissEv);
            end else if (mLat < 65535) begin
                mLat = mLat + 1;
            end
            if (mLat >= TO) mErr = 1;
        end else if (mPrevStall) begin
            if (mLat > mMax) mMax = mLat;
        end
        mPrevStall = stall;
    endtask

    task automatic setIn(input int r1, input int r2, input bit mr, input int d,
                         input bit br, input bit st);
        rs1 = AW'(r1); rs2 = AW'(r2); memRead = mr; rd = AW'(d);
        branch = br; stall = st;
    endtask

    // Close the current cycle: model and DUT both advance on this edge.
    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        rst_i = 1'b0;
        setIn(0, 0, 0, 0, 0, 0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        setIn(5, 5, 1, 5, 1, 1);
        modelReset();
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (combObs !== 5'b11000) begin
            errors++; $display("FAIL reset_comb got %b exp %b", combObs, 5'b11000);
        end
        checks++;
        if ({missActive, timeoutErr} !== 2'b00) begin
            errors++; $display("FAIL reset_flags got %b exp 00", {missActive, timeoutErr});
        end
        checks++;
        if ({loadUseCnt, missCycleCnt, missEventCnt, flushCnt, maxMissLat} !== '0) begin
            errors++; $display("FAIL reset_counters got %h exp 0",
                               {loadUseCnt, missCycleCnt, missEventCnt, flushCnt, maxMissLat});
        end
        @(posedge clk); #1;
        rst_i = 1'b1;
        setIn(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (combObs !== 5'b11000) begin
            errors++; $display("FAIL idle_comb got %b exp %b", combObs, 5'b11000);
        end
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        setIn(3, 5, 1, 5, 0, 0);
        @(negedge clk);
        checks++;
        if (combObs !== 5'b00100) begin
            errors++; $display("FAIL lu_stall got %b exp %b", combObs, 5'b00100);
        end
        tick();
        setIn(0, 0, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (combObs !== 5'b11000) begin
            errors++; $display("FAIL lu_rd_zero got %b exp %b", combObs, 5'b11000);
        end
        checks++;
        if (loadUseCnt !== CW'(cnt(1))) begin
            errors++; $display("FAIL lu_count got %0d exp %0d", loadUseCnt, cnt(1));
        end
        tick();
        setIn(6, 2, 0, 6, 0, 0);
        @(negedge clk);
        checks++;
        if (combObs !== 5'b11000) begin
            errors++; $display("FAIL lu_not_load got %b exp %b", combObs, 5'b11000);
        end
        tick();
        @(negedge clk);
        checks++;
        if (loadUseCnt !== CW'(cnt(1))) begin
            errors++; $display("FAIL lu_count_hold got %0d exp %0d", loadUseCnt, cnt(1));
        end
        tick();
    endtask

    task automatic test_branch_hazard();
        doReset();
        setIn(7, 2, 1, 7, 1, 0);
        @(negedge clk);
        checks++;
        if (combObs !== 5'b00100) begin
            errors++; $display("FAIL br_lu_comb got %b exp %b", combObs, 5'b00100);
        end
        tick();
        setIn(7, 2, 0, 7, 1, 0);
        @(negedge clk);
        checks++;
        if (combObs !== 5'b11010) begin
            errors++; $display("FAIL br_flush got %b exp %b", combObs, 5'b11010);
        end
        tick();
        setIn(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({flushCnt, loadUseCnt} !== {CW'(cnt(1)), CW'(cnt(1))}) begin
            errors++; $display("FAIL br_counts got flush %0d lu %0d exp %0d %0d",
                               flushCnt, loadUseCnt, cnt(1), cnt(1));
        end
        tick();
    endtask

    task automatic test_miss();
        doReset();
        for (int i = 1; i <= 9; i++) begin
            setIn(0, 0, 0, 0, i <= 7, i <= 7);
            @(negedge clk);
            checks++;
            if (combObs !== ((i <= 7) ? 5'b00001 : 5'b11000)) begin
                errors++; $display("FAIL miss_comb cyc %0d got %b exp %b", i, combObs,
                                   (i <= 7) ? 5'b00001 : 5'b11000);
            end
            checks++;
            if (missActive !== (i >= 2 && i <= 8)) begin
                errors++; $display("FAIL miss_active cyc %0d got %b exp %b", i, missActive,
                                   (i >= 2 && i <= 8));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({missEventCnt, missCycleCnt, maxMissLat, timeoutErr} !==
            {CW'(cnt(1)), CW'(cnt(7)), 16'(cnt(7)), 1'b0}) begin
            errors++; $display("FAIL miss_stats got ev %0d cyc %0d max %0d to %b exp %0d %0d %0d 0",
                               missEventCnt, missCycleCnt, maxMissLat, timeoutErr,
                               cnt(1), cnt(7), cnt(7));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit pat [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
        bit prev;
        doReset();
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            setIn(0, 0, 0, 0, 0, pat[i]);
            @(negedge clk);
            checks++;
            if (missActive !== prev) begin
                errors++; $display("FAIL b2b_active cyc %0d got %b exp %b", i, missActive, prev);
            end
            prev = pat[i];
            tick();
        end
        setIn(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({missEventCnt, maxMissLat, missCycleCnt} !==
            {CW'(cnt(2)), 16'(cnt(5)), CW'(cnt(8))}) begin
            errors++; $display("FAIL b2b_stats got ev %0d max %0d cyc %0d exp %0d %0d %0d",
                               missEventCnt, maxMissLat, missCycleCnt, cnt(2), cnt(5), cnt(8));
        end
        tick();
    endtask

    task automatic test_watchdog();
        doReset();
        for (int i = 1; i <= 14; i++) begin
            setIn(0, 0, 0, 0, 0, 1);
            @(negedge clk);
            checks++;
            if (timeoutErr !== (i >= TO + 1)) begin
                errors++; $display("FAIL wd_err cyc %0d got %b exp %b", i, timeoutErr, (i >= TO + 1));
            end
            tick();
        end
        setIn(0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        checks++;
        if ({timeoutErr, missActive, maxMissLat} !== {1'b1, 1'b0, 16'(cnt(14))}) begin
            errors++; $display("FAIL wd_sticky got err %b act %b max %0d exp 1 0 %0d",
                               timeoutErr, missActive, maxMissLat, cnt(14));
        end
        // Asynchronous reset between edges clears everything immediately.
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({timeoutErr, missEventCnt, missCycleCnt, maxMissLat} !== '0) begin
            errors++; $display("FAIL wd_async_clear got err %b ev %0d cyc %0d max %0d exp 0",
                               timeoutErr, missEventCnt, missCycleCnt, maxMissLat);
        end
        doReset();
        // Reset during a miss abandons the episode without updating the max.
        for (int i = 0; i < 3; i++) begin
            setIn(0, 0, 0, 0, 0, 1);
            tick();
        end
        doReset();
        @(negedge clk);
        checks++;
        if ({missActive, missEventCnt, maxMissLat} !== '0) begin
            errors++; $display("FAIL midmiss_reset got act %b ev %0d max %0d exp 0",
                               missActive, missEventCnt, maxMissLat);
        end
        tick();
    endtask

    task automatic test_saturation();
        doReset();
        for (int i = 0; i < CMAX + 8; i++) begin
            setIn(4, 1, 1, 4, 0, 0);
            tick();
        end
        setIn(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (loadUseCnt !== CW'(cnt(CMAX))) begin
            errors++; $display("FAIL sat_loaduse got %0d exp %0d", loadUseCnt, cnt(CMAX));
        end
        tick();
    endtask

    task automatic test_random();
        bit st;
        doReset();
        st = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) st = ~st;
            setIn($urandom_range(3), $urandom_range(3), 1'($urandom_range(1)),
                  $urandom_range(3), 1'($urandom_range(1)), st);
            @(negedge clk);
            checks++;
            if (combObs !== expComb()) begin
                errors++; $display("FAIL rnd_comb cyc %0d got %b exp %b", i, combObs, expComb());
            end
            checks++;
            if ({missActive, timeoutErr} !== {mPrevStall, mErr}) begin
                errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", i,
                                   {missActive, timeoutErr}, {mPrevStall, mErr});
            end
            checks++;
            if ({loadUseCnt, missCycleCnt, missEventCnt, flushCnt, maxMissLat} !==
                {CW'(cnt(mLoadUse)), CW'(cnt(mMissCyc)), CW'(cnt(mMissEv)),
                 CW'(cnt(mFlush)), 16'(cnt(mMax))}) begin
                errors++; $display("FAIL rnd_counters cyc %0d got %0d %0d %0d %0d %0d exp %0d %0d %0d %0d %0d",
                                   i, loadUseCnt, missCycleCnt, missEventCnt, flushCnt, maxMissLat,
                                   cnt(mLoadUse), cnt(mMissCyc), cnt(mMissEv), cnt(mFlush), cnt(mMax));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_hazard();
        test_miss();
        test_back_to_back();
        test_watchdog();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
